// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF sequencer.
package ro_puf_pkg;

  localparam int unsigned NUM_RO_DEFAULT = 9;
  localparam int unsigned CNT_W_DEFAULT  = 16;
  localparam int unsigned RO_IDX_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_COMPARE,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter timing the MEASURE window and the SETTLE gap.
// o_expired is high while the count is zero; a load takes priority over run.
module ro_window_timer
  import ro_puf_pkg::*;
#(
  parameter int unsigned W = 17
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_run,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Count register: load, then decrement while running until zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: enables each RO in turn for a fixed window,
// captures its edge count after a settle gap, then compares adjacent counts.
// Optional macro RO_PUF_TIE_FLAG_EN adds TIE_MARGIN and the TIE output.
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_RO        = NUM_RO_DEFAULT,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT,
  parameter int unsigned WINDOW_CYCLES = 65536,
  parameter int unsigned SETTLE_CYCLES = 4
`ifdef RO_PUF_TIE_FLAG_EN
  , parameter int unsigned TIE_MARGIN  = 2
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [7:0]          CHALLENGE,
  output logic [5:0]          RO_CHALLENGE,
  output logic [RO_IDX_W-1:0] RO_SEL,
  output logic                RO_EN,
  output logic                RO_CNT_CLR,
  input  logic [CNT_W-1:0]    RO_COUNT,
  output logic                BUSY,
  output logic                DONE,
  output logic [NUM_RO-2:0]   RESPONSE
`ifdef RO_PUF_TIE_FLAG_EN
  , output logic [NUM_RO-2:0] TIE
`endif
);

  localparam int unsigned MAX_CYC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  // The timer holds "cycles remaining minus one", so it expires on the last cycle.
  localparam logic [TW-1:0] LOAD_WIN = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] LOAD_SET = TW'(SETTLE_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [RO_IDX_W-1:0]   r_sel;
  logic [5:0]            r_chal;
  logic [CNT_W-1:0]      r_count [NUM_RO];
  logic [NUM_RO-2:0]     r_resp;
  logic [NUM_RO-2:0]     w_resp;
  logic                  w_load;
  logic [TW-1:0]         w_load_val;
  logic                  w_run;
  logic                  w_expired;
  logic                  w_last;
  logic                  w_unused_chal;

  assign w_last        = (r_sel == RO_IDX_W'(NUM_RO - 1));
  assign w_unused_chal = ^CHALLENGE[7:6];
  assign RO_CHALLENGE  = r_chal;
  assign RO_SEL        = r_sel;
  assign RESPONSE      = r_resp;

  ro_window_timer #(
    .W (TW)
  ) u_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_run      (w_run),
    .o_expired  (w_expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and Moore outputs; the timer is reloaded on the edge
  // that enters MEASURE or SETTLE so each phase starts with a fresh count.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_run       = 1'b0;
    RO_EN       = 1'b0;
    RO_CNT_CLR  = 1'b0;
    BUSY        = 1'b1;
    DONE        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        RO_CNT_CLR  = 1'b1;
        w_load      = 1'b1;
        w_load_val  = LOAD_WIN;
        w_state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        RO_EN = 1'b1;
        w_run = 1'b1;
        if (w_expired) begin
          w_load      = 1'b1;
          w_load_val  = LOAD_SET;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_run = 1'b1;
        if (w_expired) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_state_nxt = w_last ? ST_COMPARE : ST_CLEAR;
      end
      ST_COMPARE: begin
        w_state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        DONE        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        BUSY        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Adjacent unsigned comparison over the stored counts.
  always_comb begin
    w_resp = '0;
    for (int unsigned i = 0; i < NUM_RO - 1; i++) begin
      w_resp[i] = (r_count[i] > r_count[i+1]);
    end
  end

`ifdef RO_PUF_TIE_FLAG_EN
  logic [NUM_RO-2:0] w_tie;
  logic [NUM_RO-2:0] r_tie;
  assign TIE = r_tie;

  // Tie detection on the absolute difference, one bit wider than the counts.
  always_comb begin
    w_tie = '0;
    for (int unsigned i = 0; i < NUM_RO - 1; i++) begin
      if (r_count[i] >= r_count[i+1])
        w_tie[i] = (({1'b0, r_count[i]} - {1'b0, r_count[i+1]}) <= (CNT_W+1)'(TIE_MARGIN));
      else
        w_tie[i] = (({1'b0, r_count[i+1]} - {1'b0, r_count[i]}) <= (CNT_W+1)'(TIE_MARGIN));
    end
  end

  // Tie flags register and hold alongside the response.
  always_ff @(posedge CLK) begin
    if (RST)                      r_tie <= '0;
    else if (r_state == ST_COMPARE) r_tie <= w_tie;
  end
`endif

  // Datapath: challenge latch, RO index, count store and response register.
  // Count writes compare against each index rather than indexing the array
  // with r_sel, so the store stays exactly NUM_RO entries deep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sel  <= '0;
      r_chal <= '0;
      r_resp <= '0;
      for (int unsigned i = 0; i < NUM_RO; i++) r_count[i] <= '0;
    end else begin
      if ((r_state == ST_IDLE) && START) begin
        r_sel  <= '0;
        r_chal <= CHALLENGE[5:0];
      end
      if (r_state == ST_CAPTURE) begin
        for (int unsigned i = 0; i < NUM_RO; i++) begin
          if (r_sel == i[RO_IDX_W-1:0]) r_count[i] <= RO_COUNT;
        end
        if (!w_last) r_sel <= r_sel + 1'b1;
      end
      if (r_state == ST_COMPARE) r_resp <= w_resp;
    end
  end

endmodule
